// File: rtl/rb_sweep_if.sv
// -----------------------------------------------------------------------------
// rb_sweep_if
//   Bus bundle between the decode stage (master) and the rb_sweep register
//   file (slave).
//
//   Signals:
//     CLR    master->slave  restart the zero-sweep
//     RR1    master->slave  read address, port 1
//     RR2    master->slave  read address, port 2
//     wR     master->slave  write address
//     wD     master->slave  write data
//     RW     master->slave  write enable
//     RD1    slave->master  read data, port 1
//     RD2    slave->master  read data, port 2
//     READY  slave->master  array valid and accepting writes
// -----------------------------------------------------------------------------
interface rb_sweep_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    logic              CLR;
    logic [ADDR_W-1:0] RR1;
    logic [ADDR_W-1:0] RR2;
    logic [ADDR_W-1:0] wR;
    logic [DATA_W-1:0] wD;
    logic              RW;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic              READY;

    modport master (
        output CLR, RR1, RR2, wR, wD, RW,
        input  RD1, RD2, READY
    );

    modport slave (
        input  CLR, RR1, RR2, wR, wD, RW,
        output RD1, RD2, READY
    );
endinterface

// File: rtl/rb_sweep.sv
// -----------------------------------------------------------------------------
// rb_sweep
//   DATA_W x 2**ADDR_W register file: two combinational read ports, one
//   synchronous write port with same-cycle write-to-read bypass. The storage
//   array has no per-entry reset; a sweep FSM writes zero to every entry after
//   reset or a clear request and raises READY once the array is valid.
//
//   Ports:
//     CLK    clock, all state changes on the rising edge
//     RST_N  synchronous active-low reset
//     bus    rb_sweep_if.slave (CLR, RR1, RR2, wR, wD, RW -> RD1, RD2, READY)
//
//   Build option:
//     RB_ZERO_REG_EN  when defined, entry 0 reads as zero and ignores writes
//                     (the sweep still covers every entry).
// -----------------------------------------------------------------------------
module rb_sweep #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic        CLK,
    input  logic        RST_N,
    rb_sweep_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] ptr_nxt_s;

    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_data_s;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              ready_s;
    logic              wr_ok_s;

    // State and sweep pointer registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= ST_SWEEP;
            ptr_r   <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    // Storage array: no reset, contents become defined through the sweep.
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_r[mem_addr_s] <= mem_data_s;
        end
    end

    // Whether an external write is allowed to reach the array at this address.
    always_comb begin
        wr_ok_s = 1'b1;
`ifdef RB_ZERO_REG_EN
        if (bus.wR == {ADDR_W{1'b0}}) begin
            wr_ok_s = 1'b0;
        end else begin
            wr_ok_s = 1'b1;
        end
`endif
    end

    // Next-state logic and array write port selection.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        mem_we_s    = 1'b0;
        mem_addr_s  = ptr_r;
        mem_data_s  = {DATA_W{1'b0}};

        if (!RST_N) begin
            // Reset edge: the register block takes over, nothing is written.
            mem_we_s = 1'b0;
        end else begin
            case (state_r)
                ST_SWEEP: begin
                    if (bus.CLR) begin
                        // Restart: no write on the restart edge.
                        ptr_nxt_s = {ADDR_W{1'b0}};
                    end else begin
                        mem_we_s   = 1'b1;
                        mem_addr_s = ptr_r;
                        mem_data_s = {DATA_W{1'b0}};
                        // Natural wrap of the ADDR_W-bit pointer returns it to 0.
                        ptr_nxt_s  = ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        if (ptr_r == {ADDR_W{1'b1}}) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_SWEEP;
                        end
                    end
                end
                ST_IDLE: begin
                    if (bus.CLR) begin
                        // Clear wins over a simultaneous write.
                        state_nxt_s = ST_SWEEP;
                        ptr_nxt_s   = {ADDR_W{1'b0}};
                    end else if (bus.RW && wr_ok_s) begin
                        mem_we_s   = 1'b1;
                        mem_addr_s = bus.wR;
                        mem_data_s = bus.wD;
                    end else begin
                        mem_we_s = 1'b0;
                    end
                end
                default: begin
                    state_nxt_s = ST_SWEEP;
                    ptr_nxt_s   = {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    // READY is a pure decode of the state register.
    assign ready_s   = (state_r == ST_IDLE);
    assign bus.READY = ready_s;

    // Read port 1: blanked until valid, then bypass, then array.
    always_comb begin
        bus.RD1 = {DATA_W{1'b0}};
        if (!ready_s) begin
            bus.RD1 = {DATA_W{1'b0}};
`ifdef RB_ZERO_REG_EN
        end else if (bus.RR1 == {ADDR_W{1'b0}}) begin
            bus.RD1 = {DATA_W{1'b0}};
`endif
        end else if (bus.RW && (bus.RR1 == bus.wR)) begin
            bus.RD1 = bus.wD;
        end else begin
            bus.RD1 = mem_r[bus.RR1];
        end
    end

    // Read port 2: same selection as port 1, independent address.
    always_comb begin
        bus.RD2 = {DATA_W{1'b0}};
        if (!ready_s) begin
            bus.RD2 = {DATA_W{1'b0}};
`ifdef RB_ZERO_REG_EN
        end else if (bus.RR2 == {ADDR_W{1'b0}}) begin
            bus.RD2 = {DATA_W{1'b0}};
`endif
        end else if (bus.RW && (bus.RR2 == bus.wR)) begin
            bus.RD2 = bus.wD;
        end else begin
            bus.RD2 = mem_r[bus.RR2];
        end
    end

endmodule
